e203_exu_cmt_trace: RTL and testbench



---
 rtl/e203_trace_pkg.sv | 22 ++
 rtl/e203_exu_trace_fifo.sv | 59 +++++
 rtl/e203_exu_cmt_trace.sv | 130 +++++++++++++
 tb/tb_e203_exu_cmt_trace.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_trace_pkg.sv
// Shared types for the EXU commit-trace path: record kinds, the default record
// layout and default widths used by the trace capture logic.
package e203_trace_pkg;

  localparam int TRC_PC_W   = 32;
  localparam int TRC_XLEN   = 32;
  localparam int TRC_DCNT_W = 16;

  typedef enum logic [1:0] {
    TRC_RETIRE = 2'd0,
    TRC_TRAP   = 2'd1,
    TRC_MRET   = 2'd2,
    TRC_OVF    = 2'd3
  } trc_kind_e;

  typedef struct packed {
    trc_kind_e             kind;
    logic [TRC_PC_W-1:0]   pc;
    logic [TRC_XLEN-1:0]   data;
  } trc_rec_t;

endpackage

// File: rtl/e203_exu_trace_fifo.sv
// Single-clock synchronous FIFO with registered occupancy count and
// full/empty flags; head entry is read combinationally from storage.
module e203_exu_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; entries are only ever
  // read once count says they were written, so their reset value is irrelevant.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/e203_exu_cmt_trace.sv
// Commit-trace capture: selects one commit event per cycle, queues it as a
// trace record, and reports records lost to a full queue as an OVF record.
module e203_exu_cmt_trace
  import e203_trace_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32,
  parameter int DCNT_W  = TRC_DCNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trc_en,
  input  logic                      cmt_instret_ena,
  input  logic [PC_SIZE-1:0]        cmt_pc,
  input  logic [31:0]               cmt_instr,
  input  logic                      commit_trap,
  input  logic [XLEN-1:0]           cmt_cause,
  input  logic [PC_SIZE-1:0]        cmt_epc,
  input  logic                      commit_mret,
  output logic                      trc_o_valid,
  input  logic                      trc_o_ready,
  output logic [1:0]                trc_o_kind,
  output logic [PC_SIZE-1:0]        trc_o_pc,
  output logic [XLEN-1:0]           trc_o_data,
  output logic [$clog2(DEPTH):0]    trc_level,
  output logic [DCNT_W-1:0]         trc_drop_cnt
);

  localparam int RW = 2 + PC_SIZE + XLEN;
  localparam logic [DCNT_W-1:0] DCNT_MAX = '1;

  typedef struct packed {
    trc_kind_e            kind;
    logic [PC_SIZE-1:0]   pc;
    logic [XLEN-1:0]      data;
  } rec_t;

  rec_t              ev_rec;
  rec_t              wr_rec;
  rec_t              rd_rec;
  logic              ev_any;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic              ovf_emit;
  logic              ovf_pend;
  logic [DCNT_W-1:0] drop_inc;
  logic [DCNT_W-1:0] ovf_cnt;

  // NOTE: always_comb assigns every output a default first so no path can
  // leave a value held, which would otherwise infer a latch.
  always_comb begin
    ev_any = 1'b0;
    ev_rec = '0;
    if (trc_en) begin
      if (commit_trap) begin
        ev_any      = 1'b1;
        ev_rec.kind = TRC_TRAP;
        ev_rec.pc   = cmt_epc;
        ev_rec.data = cmt_cause;
      end else if (commit_mret) begin
        ev_any      = 1'b1;
        ev_rec.kind = TRC_MRET;
        ev_rec.pc   = cmt_pc;
        ev_rec.data = XLEN'(cmt_instr);
      end else if (cmt_instret_ena) begin
        ev_any      = 1'b1;
        ev_rec.kind = TRC_RETIRE;
        ev_rec.pc   = cmt_pc;
        ev_rec.data = XLEN'(cmt_instr);
      end
    end
  end

  assign drop_inc = (trc_drop_cnt == DCNT_MAX) ? trc_drop_cnt : trc_drop_cnt + 1'b1;
  // A pending overflow takes the free slot and absorbs any coincident event.
  assign ovf_cnt  = ev_any ? drop_inc : trc_drop_cnt;
  assign ovf_emit = ovf_pend & ~full;
  assign drop     = ev_any & full;
  assign push     = ovf_emit | (ev_any & ~full);
  assign pop      = trc_o_valid & trc_o_ready;

  always_comb begin
    wr_rec = ev_rec;
    if (ovf_emit) begin
      wr_rec.kind = TRC_OVF;
      wr_rec.pc   = '0;
      wr_rec.data = XLEN'(ovf_cnt);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trc_drop_cnt <= '0;
      ovf_pend     <= 1'b0;
    end else if (ovf_emit) begin
      trc_drop_cnt <= '0;
      ovf_pend     <= 1'b0;
    end else if (drop) begin
      trc_drop_cnt <= drop_inc;
      ovf_pend     <= 1'b1;
    end
  end

  e203_exu_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (rd_rec),
    .full  (full),
    .empty (empty),
    .count (trc_level)
  );

  assign trc_o_valid = ~empty;
  assign trc_o_kind  = empty ? 2'd0 : rd_rec.kind;
  assign trc_o_pc    = empty ? '0 : rd_rec.pc;
  assign trc_o_data  = empty ? '0 : rd_rec.data;

endmodule

// File: tb/tb_e203_exu_cmt_trace.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_e203_exu_cmt_trace;
  import e203_trace_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DCNT_W = 3;
  localparam int DMAX   = (1 << DCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trc_en = 1'b0;
  logic              cmt_instret_ena = 1'b0;
  logic [31:0]       cmt_pc = '0;
  logic [31:0]       cmt_instr = '0;
  logic              commit_trap = 1'b0;
  logic [31:0]       cmt_cause = '0;
  logic [31:0]       cmt_epc = '0;
  logic              commit_mret = 1'b0;
  logic              trc_o_valid;
  logic              trc_o_ready = 1'b0;
  logic [1:0]        trc_o_kind;
  logic [31:0]       trc_o_pc;
  logic [31:0]       trc_o_data;
  logic [2:0]        trc_level;
  logic [DCNT_W-1:0] trc_drop_cnt;

  int tests = 0;
  int fails = 0;

  e203_exu_cmt_trace #(
    .DEPTH(DEPTH), .PC_SIZE(32), .XLEN(32), .DCNT_W(DCNT_W)
  ) dut (
    .clk(clk), .rst(rst), .trc_en(trc_en), .cmt_instret_ena(cmt_instret_ena),
    .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .commit_trap(commit_trap),
    .cmt_cause(cmt_cause), .cmt_epc(cmt_epc), .commit_mret(commit_mret),
    .trc_o_valid(trc_o_valid), .trc_o_ready(trc_o_ready), .trc_o_kind(trc_o_kind),
    .trc_o_pc(trc_o_pc), .trc_o_data(trc_o_data), .trc_level(trc_level),
    .trc_drop_cnt(trc_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of records plus lost-record bookkeeping.
  trc_rec_t q[$];
  int       m_drop = 0;
  bit       m_pend = 0;
  trc_rec_t m_ev;
  bit       m_has_ev;
  bit       m_full;
  bit       m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_drop = 0;
      m_pend = 0;
    end else begin
      m_has_ev = trc_en && (commit_trap || commit_mret || cmt_instret_ena);
      if (commit_trap)      m_ev = '{TRC_TRAP, cmt_epc, cmt_cause};
      else if (commit_mret) m_ev = '{TRC_MRET, cmt_pc, cmt_instr};
      else                  m_ev = '{TRC_RETIRE, cmt_pc, cmt_instr};
      m_full = (q.size() == DEPTH);
      m_pop  = trc_o_ready && (q.size() > 0);
      if (m_pend && !m_full) begin
        q.push_back('{TRC_OVF, 32'd0, 32'(((m_drop + int'(m_has_ev)) > DMAX) ? DMAX : (m_drop + int'(m_has_ev)))});
        m_drop = 0;
        m_pend = 0;
      end else if (m_has_ev) begin
        if (m_full) begin
          m_drop = (m_drop == DMAX) ? DMAX : m_drop + 1;
          m_pend = 1;
        end else begin
          q.push_back(m_ev);
        end
      end
      if (m_pop) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_valid", trc_o_valid, q.size() != 0);
      check("m_level", trc_level, q.size());
      check("m_drop",  trc_drop_cnt, m_drop);
      if (q.size() != 0) begin
        check("m_kind", trc_o_kind, q[0].kind);
        check("m_pc",   trc_o_pc,   q[0].pc);
        check("m_data", trc_o_data, q[0].data);
      end else begin
        check("m_kind0", trc_o_kind, 0);
        check("m_pc0",   trc_o_pc,   0);
        check("m_data0", trc_o_data, 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit en, input bit ret, input bit trap, input bit mret,
                       input bit rdy, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] cause, input logic [31:0] epc);
    trc_en = en; cmt_instret_ena = ret; commit_trap = trap; commit_mret = mret;
    trc_o_ready = rdy; cmt_pc = pc; cmt_instr = instr; cmt_cause = cause; cmt_epc = epc;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b1, 1'b0, 1'b0, 1'b0, rdy, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic retire(input logic [31:0] pc);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pc, 32'h13, 32'd0, 32'd0);
    tick();
  endtask

  int rp;

  initial begin
    repeat (3) tick();
    check("rst_valid", trc_o_valid, 0);
    check("rst_level", trc_level, 0);
    check("rst_drop",  trc_drop_cnt, 0);
    check("rst_kind",  trc_o_kind, 0);
    check("rst_data",  trc_o_data, 0);
    rst = 1'b0;
    tick();

    // single retire
    drive(1, 1, 0, 0, 0, 32'h8000_0010, 32'h0000_0013, 0, 0);
    tick();
    check("t1_valid", trc_o_valid, 1);
    check("t1_kind",  trc_o_kind, 0);
    check("t1_pc",    trc_o_pc, 32'h8000_0010);
    check("t1_data",  trc_o_data, 32'h13);
    check("t1_level", trc_level, 1);
    idle(1); tick();

    // trap beats retire
    drive(1, 1, 1, 0, 0, 32'h8000_0040, 32'h13, 32'h2, 32'h8000_0020);
    tick();
    check("t2_level", trc_level, 1);
    check("t2_kind",  trc_o_kind, 1);
    check("t2_pc",    trc_o_pc, 32'h8000_0020);
    check("t2_data",  trc_o_data, 32'h2);
    idle(1); tick();
    check("t2_drain", trc_level, 0);

    // overflow with no coincident event
    for (int i = 0; i < 6; i++) retire(32'h100 + 32'(i * 4));
    check("t3_level", trc_level, 4);
    check("t3_drop",  trc_drop_cnt, 2);
    idle(1); tick();
    check("t3_pop_level", trc_level, 3);
    idle(0); tick();
    check("t3_ovf_level", trc_level, 4);
    check("t3_ovf_drop",  trc_drop_cnt, 0);
    idle(1); repeat (3) tick();
    check("t3_head_kind", trc_o_kind, 3);
    check("t3_head_data", trc_o_data, 2);
    check("t3_head_pc",   trc_o_pc, 0);
    tick();

    // overflow absorbing a coincident retire
    for (int i = 0; i < 7; i++) retire(32'h200 + 32'(i * 4));
    check("t4_drop", trc_drop_cnt, 3);
    idle(1); tick();
    retire(32'h300);
    check("t4_level", trc_level, 4);
    check("t4_drop0", trc_drop_cnt, 0);
    idle(1); repeat (3) tick();
    check("t4_head_kind", trc_o_kind, 3);
    check("t4_head_data", trc_o_data, 4);
    tick();
    check("t4_empty", trc_o_valid, 0);

    // capture disabled: nothing recorded, queue drains
    retire(32'h400); retire(32'h404);
    check("t5_level", trc_level, 2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i == 1, i == 2, 1, 32'h500, 32'h13, 32'h7, 32'h600);
      tick();
    end
    check("t5_level0", trc_level, 0);
    check("t5_drop",   trc_drop_cnt, 0);

    // drop counter saturation
    for (int i = 0; i < 14; i++) retire(32'h700 + 32'(i * 4));
    check("sat_drop", trc_drop_cnt, DMAX);
    idle(1); tick();
    retire(32'h800);
    idle(1); repeat (3) tick();
    check("sat_head_kind", trc_o_kind, 3);
    check("sat_head_data", trc_o_data, DMAX);
    tick();

    // async reset with level 3 and an overflow pending
    for (int i = 0; i < 5; i++) retire(32'h900 + 32'(i * 4));
    idle(1); tick();
    check("t6_level_pre", trc_level, 3);
    check("t6_drop_pre",  trc_drop_cnt, 1);
    idle(0);
    #1 rst = 1'b1;
    #1;
    check("t6_valid", trc_o_valid, 0);
    check("t6_level", trc_level, 0);
    check("t6_drop",  trc_drop_cnt, 0);
    tick();
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 32'h8000_1000, 32'h0000_0033, 0, 0);
    tick();
    check("t6_post_level", trc_level, 1);
    check("t6_post_kind",  trc_o_kind, 0);
    check("t6_post_pc",    trc_o_pc, 32'h8000_1000);

    // randomized traffic with varying consumer throughput
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(0, 2))
        0:       rp = 10;
        1:       rp = 50;
        default: rp = 90;
      endcase
      for (int c = 0; c < 100; c++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 99) < rp, $urandom, $urandom, $urandom, $urandom);
        tick();
      end
    end

    idle(1);
    repeat (12) tick();
    check("end_empty", trc_o_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
